// File: rtl/instr_mem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Define LOADER_CHECKSUM_EN to append a modulo-256 checksum byte that must match before the CPU is released.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [9:0]  word_count_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wdata_o,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
  localparam logic [2:0] S_FINISH = S_CHECK;
`else
  localparam logic [2:0] S_FINISH = S_DONE;
`endif

  // word_count_i is 10 bits, so a limit above 1023 can never clamp
  localparam logic [9:0] MAX_W = (MAX_WORDS > 1023) ? 10'd1023 : 10'(MAX_WORDS);

  logic [2:0]  state_reg,    state_next;
  logic [9:0]  count_reg,    count_next;
  logic [9:0]  written_reg,  written_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [23:0] shift_reg,    shift_next;
  logic [31:0] addr_reg,     addr_next;
  logic [31:0] wr_addr_reg,  wr_addr_next;
  logic [31:0] wr_data_reg,  wr_data_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_reg,      sum_next;
`endif

  logic       byte_fire;
  logic [9:0] clamped_count;
  logic       last_word;

  assign byte_fire     = byte_valid_i & byte_ready_o;
  assign clamped_count = (word_count_i > MAX_W) ? MAX_W : word_count_i;
  assign last_word     = ((written_reg + 10'd1) == count_reg);

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    written_next  = written_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    addr_next     = addr_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
`ifdef LOADER_CHECKSUM_EN
    sum_next      = sum_reg;
`endif
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          count_next    = clamped_count;
          written_next  = 10'd0;
          byte_idx_next = 2'd0;
          addr_next     = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
          sum_next      = 8'd0;
`endif
          state_next    = (clamped_count == 10'd0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (byte_fire) begin
          shift_next    = {shift_reg[15:0], byte_data_i};
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_next      = sum_reg + byte_data_i;
`endif
          // The 4th byte completes the word; capture it for the write cycle
          if (byte_idx_reg == 2'd3) begin
            wr_data_next = {shift_reg, byte_data_i};
            wr_addr_next = addr_reg;
            state_next   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_next     = addr_reg + 32'd4;
        written_next  = written_reg + 10'd1;
        byte_idx_next = 2'd0;
        state_next    = last_word ? S_FINISH : S_LOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_fire) begin
          state_next = (byte_data_i == sum_reg) ? S_DONE : S_ERROR;
        end
      end
      S_ERROR: begin
        state_next = S_ERROR;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      count_reg    <= 10'd0;
      written_reg  <= 10'd0;
      byte_idx_reg <= 2'd0;
      shift_reg    <= 24'd0;
      addr_reg     <= BASE_ADDR;
      wr_addr_reg  <= BASE_ADDR;
      wr_data_reg  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg      <= 8'd0;
`endif
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      written_reg  <= written_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
      addr_reg     <= addr_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
`ifdef LOADER_CHECKSUM_EN
      sum_reg      <= sum_next;
`endif
    end
  end

  assign im_we_o     = (state_reg == S_WRITE);
  assign im_addr_o   = wr_addr_reg;
  assign im_wdata_o  = wr_data_reg;
  assign done_o      = (state_reg == S_DONE);
  assign cpu_rst_n_o = (state_reg == S_DONE);

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready_o = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign busy_o       = (state_reg == S_LOAD) || (state_reg == S_WRITE) || (state_reg == S_CHECK);
  assign err_o        = (state_reg == S_ERROR);
`else
  assign byte_ready_o = (state_reg == S_LOAD);
  assign busy_o       = (state_reg == S_LOAD) || (state_reg == S_WRITE);
  assign err_o        = 1'b0;
`endif

endmodule
